i2s_line_in: RTL and testbench
==============================

Name: i2s_line_in

Overview:
- I2S master receiver for the ADC side of the Pmod I2S2 line-in. It generates MCLK, LRCK and SCLK from the 100 MHz system clock and deserialises the ADC data line.
- It presents signed 16-bit stereo sample pairs with a one-cycle valid strobe.
- It feeds recorded audio into the sig_adder / async RAM track path. It is the receive-direction counterpart to pmod_out.

Parameters:
- WARMUP_FRAMES, 4, number of complete LRCK frames discarded after enable or reset before samples are presented. Range 0..15.
- SAMPLE_PHASE, 18, value of cnt[4:0] at which the synchronised data bit is captured. It compensates the 2-flop synchroniser; the SCLK rising edge is at 16.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  receiver enable (level).
- ja_mclk  out  1  ADC master clock, clk/8 = 12.5 MHz.
- ja_lrck  out  1  word select, clk/2048 ≈ 48.83 kHz; low = left.
- ja_sclk  out  1  bit clock, clk/32 = 3.125 MHz.
- ja_sdin  in  1  ADC serial data, asynchronous to clk.
- sample_l  out  16  last left sample, two's complement.
- sample_r  out  16  last right sample, two's complement.
- sample_valid  out  1  one-cycle pulse when a new L/R pair is loaded.
- running  out  1  high in the RUN state.

Behaviour:
- Timebase: 11-bit free-running counter cnt.
  - ja_mclk = cnt[2], ja_sclk = cnt[4], ja_lrck = cnt[10]. All three are registered outputs.
  - cnt is held at 0 when not enabled, so all three clocks are low.
- Input path: ja_sdin passes through a 2-flop synchroniser (sync2). The sdin_s output is used only at the capture point.
- Slot index: slot = cnt[9:5], 0..31 within each half-frame.
  - Slot 0 is the I2S delay bit and is ignored.
  - Slots 1..16 are captured MSB-first into a 16-bit shift register, at the cycle where cnt[4:0] == SAMPLE_PHASE.
  - Slots 17..31 (ADC LSBs and padding) are ignored.
- Left half-frame: when cnt[10:0] == 1023, the shift register is copied into left_hold.
- Right half-frame: when cnt == 2047, in RUN state:
  - next cycle, sample_l <= left_hold and sample_r <= shift register;
  - sample_valid = 1 for exactly that cycle.
  - Latency is 1 clk from the last counter value of the frame.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE: cnt held at 0, clocks low, running = 0. Go to WARMUP when en = 1.
  - WARMUP: counter runs. A 4-bit frame counter increments at each cnt == 2047. Go to RUN when the frame count reaches WARMUP_FRAMES.
    - With WARMUP_FRAMES = 0, go directly from IDLE to RUN.
    - No sample_valid is asserted in WARMUP.
  - RUN: running = 1. Emit a pair every frame, one sample_valid per 2048 clk.
  - en = 0 in any state forces IDLE on the next cycle:
    - cnt, shift register, left_hold and frame counter clear;
    - sample_l and sample_r keep their last values;
    - a partial frame is discarded and no valid pulse is issued.
  - en toggling back to 1 restarts the full warmup.
- Reset: state = IDLE; cnt = 0; all clock outputs 0; sample_l = sample_r = 0; sample_valid = 0; running = 0; synchroniser flops 0. Reset mid-frame takes effect the next cycle with no valid pulse. rst has priority over en.
- No arithmetic on the sample data. It is passed through bit-exact, sign preserved.

Decomposition:
- Shared package synth_audio_pkg holds:
  - I2S timing constants: MCLK_BIT = 2, SCLK_BIT = 4, LRCK_BIT = 10, FRAME_LEN = 2048, HALF_LEN = 1024, DATA_BITS = 16, first data slot = 1;
  - FSM state encodings.
- One sub-module: sync2, a generic 2-flop synchroniser, reusable for the pmod_out and button inputs.

Test Plan:
- Reset/idle: assert rst with en = 1 for 5 cycles -> all outputs 0, clocks static. Release rst with en = 0 -> remains IDLE for 10000 cycles with no clock edges.
- Clock ratios: en = 1 with WARMUP_FRAMES = 4 -> ja_mclk period 8 clk, ja_sclk 32 clk, ja_lrck 2048 clk. First sample_valid at clk 5*2048 (+1) after enable. Pulses exactly 2048 apart, width 1.
- Data capture: an I2S ADC model drives left = 0xA5A5_3C, right = 0x1234_FF (24-bit, MSB one SCLK after LRCK edge) -> sample_l = 0xA5A5, sample_r = 0x1234 on each valid.
- Sign/extremes: model sends left 0x800000 and right 0x7FFFFF -> sample_l = 0x8000, sample_r = 0x7FFF. Then all-ones gives 0xFFFF on both.
- Enable drop mid-frame: deassert en at cnt = 1500 in RUN -> no valid that frame, clocks low next cycle, sample_l/r unchanged. Re-enable -> 4 warmup frames again before the next valid.
- Reset mid-frame: pulse rst at cnt = 700 with en = 1 -> sample_l/r = 0 next cycle. Warmup restarts; the first valid carries fresh model data, not the pre-reset partial word.

Source files
------------

// File: rtl/synth_audio_pkg.sv
// Shared audio-path definitions: I2S timing constants and receiver FSM encoding.
package synth_audio_pkg;

    localparam int unsigned MCLK_BIT        = 2;
    localparam int unsigned SCLK_BIT        = 4;
    localparam int unsigned LRCK_BIT        = 10;
    localparam int unsigned FRAME_LEN       = 2048;
    localparam int unsigned HALF_LEN        = 1024;
    localparam int unsigned DATA_BITS       = 16;
    localparam int unsigned FIRST_DATA_SLOT = 1;
    localparam int unsigned CNT_W           = 11;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StRun
    } i2s_rx_state_e;

endpackage

// File: rtl/i2s_line_in_if.sv
// Pmod I2S2 line-in pins plus the recovered stereo sample stream.
interface i2s_line_in_if;
    import synth_audio_pkg::*;

    logic                 ja_mclk;
    logic                 ja_lrck;
    logic                 ja_sclk;
    logic                 ja_sdin;
    logic [DATA_BITS-1:0] sample_l;
    logic [DATA_BITS-1:0] sample_r;
    logic                 sample_valid;
    logic                 running;

    modport master (
        output ja_mclk, ja_lrck, ja_sclk, sample_l, sample_r, sample_valid, running,
        input  ja_sdin
    );

    modport slave (
        input  ja_mclk, ja_lrck, ja_sclk, sample_l, sample_r, sample_valid, running,
        output ja_sdin
    );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous input.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2s_line_in.sv
// I2S master receiver: generates MCLK/SCLK/LRCK and deserialises the ADC into 16-bit L/R pairs.
module i2s_line_in
    import synth_audio_pkg::*;
#(
    parameter int unsigned WARMUP_FRAMES = 4,
    parameter int unsigned SAMPLE_PHASE  = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    i2s_line_in_if.master bus
);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_LEN - 1);
    localparam logic [4:0]       PHASE      = 5'(SAMPLE_PHASE);
    localparam logic [3:0]       FRAMES     = 4'(WARMUP_FRAMES);
    localparam logic [4:0]       SLOT_FIRST = 5'(FIRST_DATA_SLOT);
    localparam logic [4:0]       SLOT_LAST  = 5'(FIRST_DATA_SLOT + DATA_BITS - 1);

    i2s_rx_state_e        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           frame_q, frame_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] sample_l_q, sample_r_q;
    logic                 mclk_q, sclk_q, lrck_q, valid_q;
    logic                 load;
    logic                 sdin_s;
    logic [4:0]           slot;
    logic                 frame_end, half_end, capture;

    sync2 #(
        .RESET_VAL(1'b0)
    ) u_sync_sdin (
        .clk(clk),
        .rst(rst),
        .d  (bus.ja_sdin),
        .q  (sdin_s)
    );

    assign slot      = cnt_q[LRCK_BIT-1:SCLK_BIT+1];
    assign frame_end = (cnt_q == FRAME_LAST);
    assign half_end  = (cnt_q == HALF_LAST);
    // Capture well after the SCLK rise so the synchronised bit has settled.
    assign capture   = (state_q != StIdle) && (slot >= SLOT_FIRST) && (slot <= SLOT_LAST)
                       && (cnt_q[SCLK_BIT:0] == PHASE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        frame_d = frame_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (en) state_d = (FRAMES == 4'd0) ? StRun : StWarmup;
            end
            StWarmup: begin
                if (frame_end) begin
                    frame_d = frame_q + 1'b1;
                    if (frame_d == FRAMES) state_d = StRun;
                end
            end
            StRun:   load = frame_end;
            default: state_d = StIdle;
        endcase

        if (capture)  shift_d = {shift_q[DATA_BITS-2:0], sdin_s};
        if (half_end) hold_d  = shift_q;

        // Dropping enable abandons any partial frame; published samples are kept.
        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
            frame_d = '0;
            shift_d = '0;
            hold_d  = '0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            frame_q    <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            mclk_q     <= 1'b0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            mclk_q  <= cnt_d[MCLK_BIT];
            sclk_q  <= cnt_d[SCLK_BIT];
            lrck_q  <= cnt_d[LRCK_BIT];
            valid_q <= load;
            if (load) begin
                sample_l_q <= hold_q;
                sample_r_q <= shift_q;
            end
        end
    end

    assign bus.ja_mclk      = mclk_q;
    assign bus.ja_sclk      = sclk_q;
    assign bus.ja_lrck      = lrck_q;
    assign bus.sample_l     = sample_l_q;
    assign bus.sample_r     = sample_r_q;
    assign bus.sample_valid = valid_q;
    assign bus.running      = (state_q == StRun);

endmodule

// File: tb/tb_i2s_line_in.sv
// Bench for i2s_line_in: an I2S ADC model driven from the DUT's own clocks, directed scenarios.
module tb_i2s_line_in;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    int          checks   = 0;
    int          failures = 0;
    logic [23:0] left_word;
    logic [23:0] right_word;

    always #5 clk = ~clk;

    i2s_line_in_if bus ();

    i2s_line_in #(
        .WARMUP_FRAMES(4),
        .SAMPLE_PHASE (18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en (en),
        .bus(bus)
    );

    // ADC model: new bit after each SCLK fall, MSB one SCLK after the LRCK edge.
    // Long MCLK-low stretches mean the master stopped; realign to slot 0 of the left half.
    initial begin : codec
        bit          sclk_prev;
        bit          lr_last;
        int          idx;
        int          low_run;
        logic [23:0] cur;
        sclk_prev   = 1'b0;
        lr_last     = 1'b0;
        idx         = 0;
        low_run     = 0;
        bus.ja_sdin = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sclk_prev && !bus.ja_sclk) begin
                if (bus.ja_lrck != lr_last) idx = 0;
                else idx++;
                lr_last = bus.ja_lrck;
                cur = bus.ja_lrck ? right_word : left_word;
                if (idx == 0) bus.ja_sdin = 1'b1;
                else if (idx <= 24) bus.ja_sdin = cur[24-idx];
                else bus.ja_sdin = 1'b0;
            end
            sclk_prev = bus.ja_sclk;
            low_run = bus.ja_mclk ? 0 : low_run + 1;
            if (low_run >= 5) begin
                idx         = 0;
                lr_last     = 1'b0;
                bus.ja_sdin = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit found);
        cycles = 0;
        found  = 1'b0;
        while (cycles < budget && !found) begin
            tick();
            cycles++;
            if (bus.sample_valid) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        int         edges;
        logic [2:0] prev;
        rst = 1'b1;
        en  = 1'b1;
        tick();
        edges = 0;
        prev  = {bus.ja_mclk, bus.ja_sclk, bus.ja_lrck};
        repeat (4) begin
            tick();
            if ({bus.ja_mclk, bus.ja_sclk, bus.ja_lrck} != prev) edges++;
            prev = {bus.ja_mclk, bus.ja_sclk, bus.ja_lrck};
        end
        checks++;
        if (edges !== 0) begin
            failures++;
            $display("FAIL reset_clock_edges: got %0d expected 0", edges);
        end
        checks++;
        if ({bus.ja_mclk, bus.ja_lrck, bus.ja_sclk, bus.sample_valid, bus.running} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.ja_mclk, bus.ja_lrck, bus.ja_sclk, bus.sample_valid, bus.running});
        end
        checks++;
        if ({bus.sample_l, bus.sample_r} !== 32'h0) begin
            failures++;
            $display("FAIL reset_samples: got %h expected 00000000", {bus.sample_l, bus.sample_r});
        end
    endtask

    task automatic test_idle();
        int activity;
        rst      = 1'b0;
        en       = 1'b0;
        activity = 0;
        repeat (10000) begin
            tick();
            if (bus.ja_mclk || bus.ja_sclk || bus.ja_lrck || bus.sample_valid || bus.running)
                activity++;
        end
        checks++;
        if (activity !== 0) begin
            failures++;
            $display("FAIL idle_activity: got %0d active cycles expected 0", activity);
        end
    endtask

    task automatic test_clock_ratios();
        int n, run_cycles, cycles, spacing;
        int last_m, last_s, last_l, per_m, per_s, per_l;
        bit pm, ps, pl, found, per_bad;
        n = 0; run_cycles = 0; per_bad = 1'b0; found = 1'b0;
        last_m = -1; last_s = -1; last_l = -1; per_m = 0; per_s = 0; per_l = 0;
        pm = 1'b0; ps = 1'b0; pl = 1'b0;
        en = 1'b1;
        while (n < 12000 && !found) begin
            tick();
            n++;
            if (bus.ja_mclk && !pm) begin
                if (last_m >= 0) begin
                    if (per_m != 0 && n - last_m != per_m) per_bad = 1'b1;
                    per_m = n - last_m;
                end
                last_m = n;
            end
            if (bus.ja_sclk && !ps) begin
                if (last_s >= 0) begin
                    if (per_s != 0 && n - last_s != per_s) per_bad = 1'b1;
                    per_s = n - last_s;
                end
                last_s = n;
            end
            if (bus.ja_lrck && !pl) begin
                if (last_l >= 0) begin
                    if (per_l != 0 && n - last_l != per_l) per_bad = 1'b1;
                    per_l = n - last_l;
                end
                last_l = n;
            end
            pm = bus.ja_mclk; ps = bus.ja_sclk; pl = bus.ja_lrck;
            if (bus.sample_valid) found = 1'b1;
            else if (bus.running) run_cycles++;
        end
        checks++;
        if (!found || n !== 10241) begin
            failures++;
            $display("FAIL first_valid_latency: got %0d found=%0d expected 10241", n, found);
        end
        checks++;
        if (per_m !== 8) begin
            failures++;
            $display("FAIL mclk_period: got %0d expected 8", per_m);
        end
        checks++;
        if (per_s !== 32) begin
            failures++;
            $display("FAIL sclk_period: got %0d expected 32", per_s);
        end
        checks++;
        if (per_l !== 2048) begin
            failures++;
            $display("FAIL lrck_period: got %0d expected 2048", per_l);
        end
        checks++;
        if (per_bad !== 1'b0) begin
            failures++;
            $display("FAIL clock_period_jitter: got %0d expected 0", per_bad);
        end
        checks++;
        if (run_cycles !== 2048) begin
            failures++;
            $display("FAIL running_before_valid: got %0d expected 2048", run_cycles);
        end
        tick();
        checks++;
        if (bus.sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_width: got %b expected 0", bus.sample_valid);
        end
        wait_valid(2100, cycles, found);
        spacing = cycles + 1;
        checks++;
        if (!found || spacing !== 2048) begin
            failures++;
            $display("FAIL valid_spacing_1: got %0d found=%0d expected 2048", spacing, found);
        end
        wait_valid(2100, cycles, found);
        checks++;
        if (!found || cycles !== 2048) begin
            failures++;
            $display("FAIL valid_spacing_2: got %0d found=%0d expected 2048", cycles, found);
        end
    endtask

    task automatic test_data_capture();
        int cycles;
        bit found;
        for (int f = 0; f < 2; f++) begin
            wait_valid(2100, cycles, found);
            checks++;
            if (!found || bus.sample_l !== 16'hA5A5) begin
                failures++;
                $display("FAIL data_left_%0d: got %h found=%0d expected a5a5", f, bus.sample_l, found);
            end
            checks++;
            if (!found || bus.sample_r !== 16'h1234) begin
                failures++;
                $display("FAIL data_right_%0d: got %h found=%0d expected 1234", f, bus.sample_r, found);
            end
        end
    endtask

    task automatic test_extremes();
        int cycles;
        bit found;
        // Sitting on a valid cycle, i.e. slot 0 of the left half: safe to swap words.
        left_word  = 24'h800000;
        right_word = 24'h7FFFFF;
        wait_valid(2100, cycles, found);
        checks++;
        if (!found || {bus.sample_l, bus.sample_r} !== 32'h8000_7FFF) begin
            failures++;
            $display("FAIL extreme_signs: got %h found=%0d expected 80007fff",
                     {bus.sample_l, bus.sample_r}, found);
        end
        left_word  = 24'hFFFFFF;
        right_word = 24'hFFFFFF;
        wait_valid(2100, cycles, found);
        checks++;
        if (!found || {bus.sample_l, bus.sample_r} !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL all_ones: got %h found=%0d expected ffffffff",
                     {bus.sample_l, bus.sample_r}, found);
        end
    endtask

    task automatic test_enable_drop();
        int stray, cycles;
        bit found;
        left_word  = 24'h0F0F00;
        right_word = 24'hF0F0AA;
        stray      = 0;
        repeat (1500) begin
            tick();
            if (bus.sample_valid) stray++;
        end
        en = 1'b0;
        tick();
        checks++;
        if ({bus.ja_mclk, bus.ja_sclk, bus.ja_lrck, bus.running} !== 4'b0) begin
            failures++;
            $display("FAIL drop_clocks_low: got %b expected 0000",
                     {bus.ja_mclk, bus.ja_sclk, bus.ja_lrck, bus.running});
        end
        repeat (3000) begin
            tick();
            if (bus.sample_valid) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL drop_no_valid: got %0d pulses expected 0", stray);
        end
        checks++;
        if ({bus.sample_l, bus.sample_r} !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL drop_samples_held: got %h expected ffffffff", {bus.sample_l, bus.sample_r});
        end
        en = 1'b1;
        wait_valid(12000, cycles, found);
        checks++;
        if (!found || cycles !== 10241) begin
            failures++;
            $display("FAIL reenable_latency: got %0d found=%0d expected 10241", cycles, found);
        end
        checks++;
        if ({bus.sample_l, bus.sample_r} !== 32'h0F0F_F0F0) begin
            failures++;
            $display("FAIL reenable_data: got %h expected 0f0ff0f0", {bus.sample_l, bus.sample_r});
        end
    endtask

    task automatic test_reset_mid_frame();
        int cycles;
        bit found;
        repeat (700) tick();
        left_word  = 24'h6C3912;
        right_word = 24'h93C6FE;
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.sample_l, bus.sample_r} !== 32'h0) begin
            failures++;
            $display("FAIL midreset_samples: got %h expected 00000000", {bus.sample_l, bus.sample_r});
        end
        checks++;
        if ({bus.ja_mclk, bus.ja_sclk, bus.ja_lrck, bus.running, bus.sample_valid} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_ctrl: got %b expected 00000",
                     {bus.ja_mclk, bus.ja_sclk, bus.ja_lrck, bus.running, bus.sample_valid});
        end
        rst = 1'b0;
        wait_valid(12000, cycles, found);
        checks++;
        if (!found || cycles !== 10241) begin
            failures++;
            $display("FAIL midreset_latency: got %0d found=%0d expected 10241", cycles, found);
        end
        checks++;
        if ({bus.sample_l, bus.sample_r} !== 32'h6C39_93C6) begin
            failures++;
            $display("FAIL midreset_data: got %h expected 6c3993c6", {bus.sample_l, bus.sample_r});
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        left_word  = 24'hA5A53C;
        right_word = 24'h1234FF;
        test_reset();
        test_idle();
        test_clock_ratios();
        test_data_capture();
        test_extremes();
        test_enable_drop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
